lfsr_dcnt_param: RTL and testbench

- Parametrised shift-register counter with synchronous load, count enable and programmable terminal-count compare.
- Generalises the team's fixed 6-bit twisted-ring counter in three ways: configurable width, a run-time selectable maximal-length LFSR mode, and optional auto-reload on terminal count.
- Adds a registered terminal-count pulse and lockup detection/recovery.
- Used as a cheap divider and timeout generator in datapath control.

---
 rtl/lfsr_dcnt_param.sv | 66 ++++++
 tb/tb_lfsr_dcnt_param.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lfsr_dcnt_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lfsr_dcnt_param: Johnson/LFSR shift counter with load, reload and TC pulse |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lfsr_dcnt_param #(
  parameter int                 WIDTH = 6,
  parameter logic [WIDTH-1:0]   POLY  = WIDTH'(6'b000011)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] count_to,
  input  logic             load,
  input  logic             cen,
  input  logic             mode,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count,
  output logic             tercnt,
  output logic             tc_pulse,
  output logic             lockup_err
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc_pulse;
  logic             r_lockup_err;

  logic             w_tercnt;
  logic             w_all_ones;
  logic             w_fb;
  logic [WIDTH-1:0] w_step;

  assign w_tercnt   = (r_count == count_to);
  assign w_all_ones = &r_count;
  // XNOR feedback makes all-ones the stuck state, so all-zero stays a legal start
  assign w_fb       = mode ? ~^(r_count & POLY) : ~r_count[0];
  assign w_step     = {w_fb, r_count[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count      <= '0;
      r_tc_pulse   <= 1'b0;
      r_lockup_err <= 1'b0;
    end else begin
      r_tc_pulse <= cen && w_tercnt && !load;
      if (load) begin
        r_count      <= data;
        r_lockup_err <= 1'b0;
      end else if (cen && w_tercnt && reload_en) begin
        r_count <= data;
      end else if (cen && mode && w_all_ones) begin
        r_count      <= '0;
        r_lockup_err <= 1'b1;
      end else if (cen) begin
        r_count <= w_step;
      end
    end
  end

  assign count      = r_count;
  assign tercnt     = w_tercnt;
  assign tc_pulse   = r_tc_pulse;
  assign lockup_err = r_lockup_err;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_dcnt_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lfsr_dcnt_param: scoreboard bench for lfsr_dcnt_param (WIDTH=6)         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_lfsr_dcnt_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] data, count_to, count;
  logic       load, cen, mode, reload_en;
  logic       tercnt, tc_pulse, lockup_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0] cnt;
    logic       cc;
    logic       ter;
    logic       tc;
    logic       lk;
  } exp_t;

  exp_t sb[$];

  lfsr_dcnt_param #(.WIDTH(6), .POLY(6'b000011)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .count_to  (count_to),
    .load      (load),
    .cen       (cen),
    .mode      (mode),
    .reload_en (reload_en),
    .count     (count),
    .tercnt    (tercnt),
    .tc_pulse  (tc_pulse),
    .lockup_err(lockup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic cyc(input logic ld, input logic [5:0] d, input logic ce, input logic md,
                     input logic re, input logic [5:0] ct, input logic [5:0] ec,
                     input logic cc, input logic et, input logic elk);
    exp_t e;
    load = ld; data = d; cen = ce; mode = md; reload_en = re; count_to = ct;
    sb.push_back('{ec, cc, cc ? (ec == ct) : 1'b0, et, elk});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.cc) chk("count", {26'd0, count}, {26'd0, e.cnt});
    chk("tercnt", {31'd0, tercnt}, {31'd0, e.ter});
    chk("tc_pulse", {31'd0, tc_pulse}, {31'd0, e.tc});
    chk("lockup_err", {31'd0, lockup_err}, {31'd0, e.lk});
  endtask

  logic [5:0] john_tab [12] = '{6'h20, 6'h30, 6'h38, 6'h3C, 6'h3E, 6'h3F,
                                6'h1F, 6'h0F, 6'h07, 6'h03, 6'h01, 6'h00};
  logic [5:0] lfsr_tab [6]  = '{6'h20, 6'h30, 6'h38, 6'h3C, 6'h3E, 6'h1F};

  initial begin
    int first_zero;
    reset = 1'b0;
    load = 1'b0; data = '0; cen = 1'b0; mode = 1'b0; reload_en = 1'b0; count_to = 6'h2A;

    // Reset dominates a pending load
    cyc(1, 6'h15, 0, 0, 0, 6'h2A, 6'h00, 1, 0, 0);
    cyc(1, 6'h15, 0, 0, 0, 6'h2A, 6'h00, 1, 0, 0);
    reset = 1'b1;
    cyc(1, 6'h15, 0, 0, 0, 6'h2A, 6'h15, 1, 0, 0);

    // Johnson: 12-step period, 0x3F visited without a lockup flag
    cyc(1, 6'h00, 0, 0, 0, 6'h2A, 6'h00, 1, 0, 0);
    for (int i = 0; i < 12; i++)
      cyc(0, 6'h00, 1, 0, 0, 6'h2A, john_tab[i], 1, 0, 0);
    cyc(0, 6'h00, 0, 0, 0, 6'h2A, 6'h00, 1, 0, 0);
    cyc(0, 6'h00, 0, 0, 0, 6'h2A, 6'h00, 1, 0, 0);

    // LFSR: 63-step period, never reaches all-ones
    first_zero = 0;
    for (int i = 1; i <= 63; i++) begin
      cyc(0, 6'h00, 1, 1, 0, 6'h3F, (i <= 6) ? lfsr_tab[i-1] : 6'h00, (i <= 6), 0, 0);
      chk("lfsr_no_ones", {31'd0, (count == 6'h3F)}, 32'd0);
      if (count == 6'h00 && first_zero == 0) first_zero = i;
    end
    chk("lfsr_period", first_zero, 63);

    // Load beats cen, and suppresses tc_pulse even with tercnt high
    cyc(1, 6'h2A, 1, 1, 0, 6'h00, 6'h2A, 1, 0, 0);
    cyc(0, 6'h2A, 0, 1, 0, 6'h00, 6'h2A, 1, 0, 0);

    // Reload on terminal count
    cyc(1, 6'h00, 0, 0, 1, 6'h38, 6'h00, 1, 0, 0);
    cyc(0, 6'h00, 1, 0, 1, 6'h38, 6'h20, 1, 0, 0);
    cyc(0, 6'h00, 1, 0, 1, 6'h38, 6'h30, 1, 0, 0);
    cyc(0, 6'h00, 1, 0, 1, 6'h38, 6'h38, 1, 0, 0);
    cyc(0, 6'h00, 1, 0, 1, 6'h38, 6'h00, 1, 1, 0);
    cyc(0, 6'h00, 0, 0, 1, 6'h38, 6'h00, 1, 0, 0);

    // Wrap without reload: steps through count_to, still one pulse
    cyc(0, 6'h00, 1, 0, 0, 6'h38, 6'h20, 1, 0, 0);
    cyc(0, 6'h00, 1, 0, 0, 6'h38, 6'h30, 1, 0, 0);
    cyc(0, 6'h00, 1, 0, 0, 6'h38, 6'h38, 1, 0, 0);
    cyc(0, 6'h00, 1, 0, 0, 6'h38, 6'h3C, 1, 1, 0);
    cyc(0, 6'h00, 0, 0, 0, 6'h38, 6'h3C, 1, 0, 0);

    // Lockup recovery and sticky flag, cleared by load
    cyc(1, 6'h3F, 0, 1, 0, 6'h38, 6'h3F, 1, 0, 0);
    cyc(0, 6'h00, 1, 1, 0, 6'h38, 6'h00, 1, 0, 1);
    cyc(0, 6'h00, 1, 1, 0, 6'h38, 6'h20, 1, 0, 1);
    cyc(0, 6'h00, 1, 1, 0, 6'h38, 6'h30, 1, 0, 1);
    cyc(1, 6'h05, 0, 1, 0, 6'h38, 6'h05, 1, 0, 0);

    // Reset clears the flag too
    cyc(1, 6'h3F, 0, 1, 0, 6'h38, 6'h3F, 1, 0, 0);
    cyc(0, 6'h00, 1, 1, 0, 6'h38, 6'h00, 1, 0, 1);
    reset = 1'b0;
    cyc(0, 6'h00, 1, 1, 0, 6'h38, 6'h00, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
